strela_reg_master: RTL and testbench
====================================

STRELA_REG_MASTER -- requirements
Module: strela_reg_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter POLL_TIMEOUT, default 1024, meaning maximum read attempts per POLL command (>=1).
REQ-003 SHALL have port clk_i, input, 1, meaning the single clock.
REQ-004 SHALL have port rst_ni, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port cmd_valid_i, input, 1, meaning command offered.
REQ-006 SHALL have port cmd_ready_o, output, 1, meaning FIFO not full.
REQ-007 SHALL have port cmd_op_i, input, 2, meaning 00 WRITE, 01 READ, 10 POLL, 11 reserved.
REQ-008 SHALL have port cmd_addr_i, input, 32, meaning register byte address.
REQ-009 SHALL have port cmd_data_i, input, 32, meaning write data for WRITE and bit mask for POLL.
REQ-010 SHALL have port reg_req_o, output, reg_req_t, meaning register-bus request (addr, write, wdata, wstrb, valid).
REQ-011 SHALL have port reg_rsp_i, input, reg_rsp_t, meaning register-bus response (rdata, error, ready).
REQ-012 SHALL have port rsp_valid_o, output, 1, meaning one-cycle completion pulse.
REQ-013 SHALL have port rsp_data_o, output, 32, meaning read data of the completed command.
REQ-014 SHALL have port rsp_error_o, output, 1, meaning bus error or reserved op.
REQ-015 SHALL have port rsp_timeout_o, output, 1, meaning POLL exhausted its attempts.
REQ-016 SHALL have port busy_o, output, 1, meaning FIFO non-empty or FSM not IDLE.

Function
REQ-017 SHALL accept a command on cmd_valid_i && cmd_ready_o; cmd_ready_o = !full, with no same-cycle pop bypass.
REQ-018 SHALL process commands strictly in order, one bus transaction at a time.
REQ-019 SHALL implement FSM IDLE -> ACCESS -> GAP -> IDLE, with all reg_req_o fields registered.
REQ-020 IDLE: if FIFO non-empty, SHALL pop the head, load the request registers, and enter ACCESS next cycle.
REQ-021 Latency: a command pushed into an empty FIFO at cycle N SHALL see reg_req_o.valid=1 at cycle N+2.
REQ-022 ACCESS: SHALL hold valid, addr, write, wdata and wstrb stable until reg_rsp_i.ready=1.
REQ-023 WRITE: SHALL drive write=1, wstrb=4'hF, wdata=cmd data; READ and POLL: SHALL drive write=0, wstrb=0, wdata=0.
REQ-024 On a ready cycle in ACCESS, SHALL capture rdata and error and enter GAP, driving valid=0 for exactly one cycle.
REQ-025 WRITE or READ completion: rsp_valid_o SHALL pulse in the GAP cycle; rsp_data_o = rdata for READ, 0 for WRITE; rsp_error_o = captured error.
REQ-026 POLL: a read with (rdata & mask) != 0 or error=1 SHALL complete the command (pulse in GAP; timeout=0).
REQ-027 POLL: otherwise the attempt counter SHALL increment, and if attempts == POLL_TIMEOUT the command SHALL complete with rsp_timeout_o=1 and rsp_data_o = last rdata.
REQ-028 POLL: otherwise the FSM SHALL go GAP -> ACCESS to re-issue the same read; the counter SHALL clear at every command start.
REQ-029 POLL with mask 0 SHALL perform exactly POLL_TIMEOUT reads and then time out.
REQ-030 Reserved op SHALL skip bus access (IDLE -> GAP) and pulse rsp_valid_o with rsp_error_o=1 and rsp_data_o=0.
REQ-031 rsp_data_o, rsp_error_o and rsp_timeout_o SHALL be valid only while rsp_valid_o=1 and SHALL read 0 otherwise.
REQ-032 A push in the same cycle as a pop on a non-full FIFO SHALL be accepted, with the count unchanged.

Reset
REQ-033 On rst_ni=0, asynchronously: FSM=IDLE, FIFO empty, counter=0, all reg_req_o fields=0, rsp_* outputs=0, busy_o=0, cmd_ready_o=1.
REQ-034 Reset during ACCESS SHALL drop reg_req_o.valid immediately, discard the in-flight and queued commands, and emit no rsp_valid_o.

Verification
REQ-035 WRITE 0x10 data 0xDEADBEEF, ready after 2 cycles -> valid high 3 cycles with write=1, wstrb=F; one rsp pulse with data=0, error=0.
REQ-036 READ 0x04, slave returns 0x3 with error=1 -> rsp_data_o=0x3, rsp_error_o=1, valid low for exactly one cycle afterwards.
REQ-037 POLL 0x04 mask 0x1, rdata 0,0,1 -> 3 bus reads separated by 1-cycle gaps; rsp_data_o=0x1, timeout=0.
REQ-038 POLL_TIMEOUT=4, POLL mask 0x2, rdata always 0 -> 4 reads, then rsp_timeout_o=1, rsp_data_o=0.
REQ-039 Push 5 commands back-to-back with FIFO_DEPTH=4 and slave stalled -> cmd_ready_o low after the 5th accepted (4 queued + 1 in flight); responses return in order, then busy_o=0.
REQ-040 Assert rst_ni=0 mid-ACCESS with 2 commands queued -> valid=0 the same cycle, no response pulse, busy_o=0 after release.

Source files
------------

// File: rtl/strela_reg_master.sv
// strela_reg_master: in-order WRITE/READ/POLL command queue driving a single-outstanding register bus.
// Latency: a command pushed into an empty queue at cycle N raises reg_req_o.valid at N+2; one idle gap after every response.
// Backpressure: cmd_ready_o drops while the queue is full; reg_req_o is held stable until reg_rsp_i.ready.

typedef struct packed {
   logic [31:0] addr;
   logic        write;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        valid;
} reg_req_t;

typedef struct packed {
   logic [31:0] rdata;
   logic        error;
   logic        ready;
} reg_rsp_t;

module strela_reg_master #(
   parameter int FIFO_DEPTH   = 4,
   parameter int POLL_TIMEOUT = 1024
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   output reg_req_t    reg_req_o,
   input  reg_rsp_t    reg_rsp_i,
   output logic        rsp_valid_o,
   output logic [31:0] rsp_data_o,
   output logic        rsp_error_o,
   output logic        rsp_timeout_o,
   output logic        busy_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);

   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_POLL  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_GAP    = 2'd2;

   localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] POLL_LIMIT = CNT_W'(POLL_TIMEOUT);

   // command queue storage and bookkeeping
   logic [1:0]       fifo_op   [FIFO_DEPTH];
   logic [31:0]      fifo_addr [FIFO_DEPTH];
   logic [31:0]      fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // sequencer state
   logic [1:0]       state;
   logic [1:0]       cur_op;
   logic [31:0]      mask;
   logic [CNT_W-1:0] attempts;
   logic [CNT_W-1:0] attempts_inc;
   logic             retry;
   logic             poll_hit;
   reg_req_t         req;

   logic             rsp_valid;
   logic [31:0]      rsp_data;
   logic             rsp_error;
   logic             rsp_timeout;

   logic [1:0]       head_op;
   logic [31:0]      head_addr;
   logic [31:0]      head_data;

   assign full         = (count == FIFO_FULL);
   assign empty        = (count == '0);
   assign push         = cmd_valid_i && !full;
   assign pop          = (state == ST_IDLE) && !empty;
   assign head_op      = fifo_op[rd_ptr];
   assign head_addr    = fifo_addr[rd_ptr];
   assign head_data    = fifo_data[rd_ptr];
   assign attempts_inc = attempts + CNT_W'(1);
   assign poll_hit     = ((reg_rsp_i.rdata & mask) != 32'h0) || reg_rsp_i.error;

   assign cmd_ready_o   = !full;
   assign busy_o        = !empty || (state != ST_IDLE);
   assign reg_req_o     = req;
   assign rsp_valid_o   = rsp_valid;
   assign rsp_data_o    = rsp_data;
   assign rsp_error_o   = rsp_error;
   assign rsp_timeout_o = rsp_timeout;

   // queue payload: written on accept, no reset needed since occupancy gates every read
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_op[wr_ptr]   <= cmd_op_i;
         fifo_addr[wr_ptr] <= cmd_addr_i;
         fifo_data[wr_ptr] <= cmd_data_i;
      end
   end

   // queue pointers and occupancy; a simultaneous push and pop leaves the count unchanged
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // IDLE -> ACCESS -> GAP -> IDLE sequencer; responses are a single-cycle pulse in GAP
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         cur_op      <= OP_WRITE;
         mask        <= '0;
         attempts    <= '0;
         retry       <= 1'b0;
         req         <= '0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         // response fields read zero outside the pulse
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!empty) begin
                  cur_op   <= head_op;
                  mask     <= head_data;
                  attempts <= '0;
                  retry    <= 1'b0;
                  if (head_op == OP_RSVD) begin
                     // reserved op never touches the bus
                     state     <= ST_GAP;
                     rsp_valid <= 1'b1;
                     rsp_error <= 1'b1;
                  end else begin
                     state       <= ST_ACCESS;
                     req.valid   <= 1'b1;
                     req.addr    <= head_addr;
                     req.write   <= (head_op == OP_WRITE);
                     req.wdata   <= (head_op == OP_WRITE) ? head_data : 32'h0;
                     req.wstrb   <= (head_op == OP_WRITE) ? 4'hF : 4'h0;
                  end
               end
            end
            ST_ACCESS: begin
               if (reg_rsp_i.ready) begin
                  req.valid <= 1'b0;
                  state     <= ST_GAP;
                  if (cur_op != OP_POLL) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= (cur_op == OP_READ) ? reg_rsp_i.rdata : 32'h0;
                     rsp_error <= reg_rsp_i.error;
                  end else if (poll_hit) begin
                     rsp_valid <= 1'b1;
                     rsp_data  <= reg_rsp_i.rdata;
                     rsp_error <= reg_rsp_i.error;
                  end else begin
                     attempts <= attempts_inc;
                     if (attempts_inc == POLL_LIMIT) begin
                        rsp_valid   <= 1'b1;
                        rsp_data    <= reg_rsp_i.rdata;
                        rsp_timeout <= 1'b1;
                     end else begin
                        retry <= 1'b1;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (retry) begin
                  // re-issue the same read; address and strobes are still loaded
                  retry     <= 1'b0;
                  req.valid <= 1'b1;
                  state     <= ST_ACCESS;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_strela_reg_master.sv
// Directed bench for strela_reg_master: a scripted register slave, a command-level expectation model,
// and one per-cycle compare process checking bus transfers and responses against that model.
module tb_strela_reg_master;

   localparam int DEPTH = 4;
   localparam int PT    = 4;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i = 2'b00;
   logic [31:0] cmd_addr_i = 32'h0;
   logic [31:0] cmd_data_i = 32'h0;
   reg_req_t    reg_req_o;
   reg_rsp_t    reg_rsp_i;
   logic        rsp_valid_o;
   logic [31:0] rsp_data_o;
   logic        rsp_error_o;
   logic        rsp_timeout_o;
   logic        busy_o;

   strela_reg_master #(.FIFO_DEPTH(DEPTH), .POLL_TIMEOUT(PT)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_addr_i(cmd_addr_i), .cmd_data_i(cmd_data_i),
      .reg_req_o(reg_req_o), .reg_rsp_i(reg_rsp_i),
      .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
      .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { int lat; logic [31:0] rdata; logic err; } slv_t;
   typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb; int lat; } xfer_t;
   typedef struct { logic [31:0] data; logic err; logic to; } rsp_t;

   slv_t  slv_q[$];
   slv_t  mdl_q[$];
   xfer_t exp_x[$];
   rsp_t  exp_r[$];

   int total = 0;
   int bad = 0;
   int nxfer = 0;
   int nrsp = 0;
   int last_run = 0;
   logic [31:0] last_data = 32'h0;
   logic last_err = 1'b0;
   logic last_to = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   // one scripted slave reply; both the slave and the model consume the same sequence
   function automatic void slv(input int lat, input logic [31:0] rd, input logic err);
      slv_t s;
      s.lat = lat; s.rdata = rd; s.err = err;
      slv_q.push_back(s);
      mdl_q.push_back(s);
   endfunction

   // command-level model: which bus transfers a command causes and what it reports
   function automatic void model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      slv_t  s;
      xfer_t x;
      rsp_t  r;
      bit    done;
      r.data = 32'h0; r.err = 1'b0; r.to = 1'b0;
      x.addr  = addr;
      x.write = (op == 2'b00);
      x.wdata = (op == 2'b00) ? data : 32'h0;
      x.wstrb = (op == 2'b00) ? 4'hF : 4'h0;
      x.lat   = 0;
      case (op)
         2'b00, 2'b01: begin
            s = mdl_q.pop_front();
            x.lat = s.lat;
            exp_x.push_back(x);
            r.data = (op == 2'b01) ? s.rdata : 32'h0;
            r.err  = s.err;
         end
         2'b10: begin
            done = 1'b0;
            for (int k = 0; k < PT && !done; k++) begin
               s = mdl_q.pop_front();
               x.lat = s.lat;
               exp_x.push_back(x);
               r.data = s.rdata;
               if (((s.rdata & data) != 32'h0) || s.err) begin
                  done  = 1'b1;
                  r.err = s.err;
               end
            end
            r.to = !done;
         end
         default: r.err = 1'b1;
      endcase
      exp_r.push_back(r);
   endfunction

   // called at a negedge, returns at the negedge after the accepting edge
   task automatic push(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      int n;
      n = 0;
      model(op, addr, data);
      cmd_valid_i = 1'b1; cmd_op_i = op; cmd_addr_i = addr; cmd_data_i = data;
      while (!cmd_ready_o && n < 300) begin
         @(negedge clk_i);
         n++;
      end
      chk("push accepted in time", 32'(n < 300), 32'd1);
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((busy_o || exp_r.size() != 0 || exp_x.size() != 0) && n < 1000) begin
         @(negedge clk_i);
         n++;
      end
      chk("drain in time", 32'(n < 1000), 32'd1);
   endtask

   // scripted slave: raises ready after 'lat' wait cycles of valid
   initial begin
      int   cnt;
      bit   hs;
      slv_t s;
      cnt = 0; hs = 1'b0;
      reg_rsp_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         if (!rst_ni) begin
            cnt = 0; hs = 1'b0;
            reg_rsp_i = '0;
         end else begin
            if (hs) begin
               if (slv_q.size() != 0) void'(slv_q.pop_front());
               cnt = 0; hs = 1'b0;
            end
            reg_rsp_i.ready = 1'b0;
            reg_rsp_i.rdata = 32'hA5A5_5A5A;
            reg_rsp_i.error = 1'b1;
            if (reg_req_o.valid) begin
               if (slv_q.size() == 0) begin
                  s.lat = 0; s.rdata = 32'h0; s.err = 1'b0;
               end else begin
                  s = slv_q[0];
               end
               if (cnt >= s.lat) begin
                  reg_rsp_i.ready = 1'b1;
                  reg_rsp_i.rdata = s.rdata;
                  reg_rsp_i.error = s.err;
                  hs = 1'b1;
               end else begin
                  cnt++;
               end
            end
         end
      end
   end

   // per-cycle compare of bus transfers and responses against the model queues
   initial begin
      int    run;
      bit    prev_hs;
      xfer_t x;
      rsp_t  r;
      run = 0; prev_hs = 1'b0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            run = 0; prev_hs = 1'b0;
         end else begin
            if (rsp_valid_o) begin
               chk("rsp expected", 32'(exp_r.size() != 0), 32'd1);
               if (exp_r.size() != 0) begin
                  r = exp_r.pop_front();
                  chk("rsp_data", rsp_data_o, r.data);
                  chk("rsp_error", 32'(rsp_error_o), 32'(r.err));
                  chk("rsp_timeout", 32'(rsp_timeout_o), 32'(r.to));
               end
               nrsp++;
               last_data = rsp_data_o; last_err = rsp_error_o; last_to = rsp_timeout_o;
            end else begin
               chk("rsp_data idle", rsp_data_o, 32'h0);
               chk("rsp_error idle", 32'(rsp_error_o), 32'd0);
               chk("rsp_timeout idle", 32'(rsp_timeout_o), 32'd0);
            end
            if (prev_hs) chk("gap valid low", 32'(reg_req_o.valid), 32'd0);
            prev_hs = 1'b0;
            if (reg_req_o.valid) begin
               chk("xfer expected", 32'(exp_x.size() != 0), 32'd1);
               run++;
               if (exp_x.size() != 0) begin
                  x = exp_x[0];
                  chk("req addr", reg_req_o.addr, x.addr);
                  chk("req write", 32'(reg_req_o.write), 32'(x.write));
                  chk("req wdata", reg_req_o.wdata, x.wdata);
                  chk("req wstrb", 32'(reg_req_o.wstrb), 32'(x.wstrb));
               end
               if (reg_rsp_i.ready) begin
                  if (exp_x.size() != 0) begin
                     chk("valid cycles", 32'(run), 32'(x.lat + 1));
                     void'(exp_x.pop_front());
                  end
                  nxfer++;
                  last_run = run;
                  run = 0;
                  prev_hs = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int bx, br, n;
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("reset req addr", reg_req_o.addr, 32'h0);
      chk("reset req wdata", reg_req_o.wdata, 32'h0);
      chk("reset req ctl", 32'({reg_req_o.write, reg_req_o.wstrb, reg_req_o.valid}), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("reset rsp_data", rsp_data_o, 32'h0);
      chk("reset busy", 32'(busy_o), 32'd0);
      chk("reset cmd_ready", 32'(cmd_ready_o), 32'd1);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // WRITE 0x10, ready after 2 wait cycles
      slv(2, 32'h1234_5678, 1'b0);
      bx = nxfer; br = nrsp;
      push(2'b00, 32'h10, 32'hDEAD_BEEF);
      chk("latency N+1 valid", 32'(reg_req_o.valid), 32'd0);
      chk("busy after push", 32'(busy_o), 32'd1);
      @(negedge clk_i);
      chk("latency N+2 valid", 32'(reg_req_o.valid), 32'd1);
      chk("write strobes", 32'(reg_req_o.wstrb), 32'hF);
      drain();
      chk("write xfers", 32'(nxfer - bx), 32'd1);
      chk("write valid cycles", 32'(last_run), 32'd3);
      chk("write rsp count", 32'(nrsp - br), 32'd1);
      chk("write rsp data", last_data, 32'h0);
      chk("write rsp error", 32'(last_err), 32'd0);

      // READ with bus error
      slv(0, 32'h3, 1'b1);
      push(2'b01, 32'h04, 32'h0);
      drain();
      chk("read rsp data", last_data, 32'h3);
      chk("read rsp error", 32'(last_err), 32'd1);

      // POLL hits on third read
      slv(0, 32'h0, 1'b0); slv(1, 32'h0, 1'b0); slv(0, 32'h1, 1'b0);
      bx = nxfer;
      push(2'b10, 32'h04, 32'h1);
      drain();
      chk("poll hit xfers", 32'(nxfer - bx), 32'd3);
      chk("poll hit data", last_data, 32'h1);
      chk("poll hit timeout", 32'(last_to), 32'd0);

      // POLL never matches: four reads then timeout
      for (int i = 0; i < PT; i++) slv(0, 32'h0, 1'b0);
      bx = nxfer;
      push(2'b10, 32'h04, 32'h2);
      drain();
      chk("poll timeout xfers", 32'(nxfer - bx), 32'd4);
      chk("poll timeout flag", 32'(last_to), 32'd1);
      chk("poll timeout data", last_data, 32'h0);

      // timeout reports the last (non-matching) read data
      for (int i = 0; i < PT; i++) slv(i, 32'hFD, 1'b0);
      push(2'b10, 32'h0C, 32'h2);
      drain();
      chk("poll timeout last data", last_data, 32'hFD);
      chk("poll timeout last flag", 32'(last_to), 32'd1);

      // POLL ends early on bus error
      slv(0, 32'h0, 1'b0); slv(1, 32'h0, 1'b1);
      bx = nxfer;
      push(2'b10, 32'h08, 32'h1);
      drain();
      chk("poll error xfers", 32'(nxfer - bx), 32'd2);
      chk("poll error flag", 32'(last_err), 32'd1);
      chk("poll error timeout", 32'(last_to), 32'd0);

      // reserved op: no bus access, error response
      bx = nxfer; br = nrsp;
      push(2'b11, 32'h20, 32'h55);
      drain();
      chk("rsvd xfers", 32'(nxfer - bx), 32'd0);
      chk("rsvd rsp count", 32'(nrsp - br), 32'd1);
      chk("rsvd error", 32'(last_err), 32'd1);
      chk("rsvd data", last_data, 32'h0);

      // five back-to-back commands with the first access stalled
      slv(10, 32'h0, 1'b0); slv(1, 32'hCAFE, 1'b0); slv(0, 32'h0, 1'b0);
      slv(2, 32'h7, 1'b0); slv(0, 32'h80, 1'b0);
      br = nrsp;
      push(2'b00, 32'h100, 32'h11);
      push(2'b01, 32'h104, 32'h0);
      push(2'b00, 32'h108, 32'h22);
      push(2'b01, 32'h10C, 32'h0);
      push(2'b10, 32'h110, 32'h80);
      chk("full after five", 32'(cmd_ready_o), 32'd0);
      drain();
      chk("burst rsp count", 32'(nrsp - br), 32'd5);
      chk("burst busy idle", 32'(busy_o), 32'd0);
      chk("burst last data", last_data, 32'h80);

      // reset in the middle of an access with two commands queued
      slv(50, 32'h0, 1'b0); slv(0, 32'h0, 1'b0); slv(0, 32'h0, 1'b0);
      push(2'b00, 32'h200, 32'h1);
      push(2'b01, 32'h204, 32'h0);
      push(2'b00, 32'h208, 32'h2);
      n = 0;
      while (!reg_req_o.valid && n < 50) begin
         @(negedge clk_i);
         n++;
      end
      chk("access before reset", 32'(reg_req_o.valid), 32'd1);
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("reset drops valid", 32'(reg_req_o.valid), 32'd0);
      chk("reset clears busy", 32'(busy_o), 32'd0);
      chk("reset ready", 32'(cmd_ready_o), 32'd1);
      chk("reset rsp_valid mid", 32'(rsp_valid_o), 32'd0);
      exp_x.delete(); exp_r.delete(); slv_q.delete(); mdl_q.delete();
      br = nrsp;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (10) @(negedge clk_i);
      chk("post reset busy", 32'(busy_o), 32'd0);
      chk("post reset no rsp", 32'(nrsp - br), 32'd0);
      chk("post reset valid", 32'(reg_req_o.valid), 32'd0);

      // normal operation after reset
      slv(1, 32'h99, 1'b0);
      push(2'b01, 32'h300, 32'h0);
      drain();
      chk("post reset read data", last_data, 32'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
